// File: rtl/feature_pkg.sv
// Shared defaults and helpers for the feature-point ROI extractor.
// Optional run thinning is selected with FEATURE_THIN_EN (see feature_point_roi).
package feature_pkg;

    localparam int unsigned COORD_W_DEF = 12;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned MAX_BUS_W   = 8 * 32;

    function automatic int unsigned ROI_IDX_W(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Field idx of width w from a packed bus zero-extended to MAX_BUS_W.
    function automatic logic [31:0] bus_field(input logic [MAX_BUS_W-1:0] bus,
                                              input int unsigned idx,
                                              input int unsigned w);
        logic [MAX_BUS_W-1:0] sh;
        sh = bus >> (idx * w);
        return sh[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/feature_point_roi_roi_match.sv
// Combinational inclusive-bounds region test with lowest-index priority.
module roi_match
    import feature_pkg::*;
#(
    parameter int unsigned NUM_ROI = 2,
    parameter int unsigned COORD_W = COORD_W_DEF
) (
    input  logic [COORD_W-1:0]            x,
    input  logic [COORD_W-1:0]            y,
    input  logic [NUM_ROI*COORD_W-1:0]    x_min,
    input  logic [NUM_ROI*COORD_W-1:0]    x_max,
    input  logic [NUM_ROI*COORD_W-1:0]    y_min,
    input  logic [NUM_ROI*COORD_W-1:0]    y_max,
    output logic                          hit,
    output logic [ROI_IDX_W(NUM_ROI)-1:0] idx
);
    localparam int unsigned IDX_W = ROI_IDX_W(NUM_ROI);

    logic [MAX_BUS_W-1:0] x_min_w, x_max_w, y_min_w, y_max_w;

    always_comb begin
        x_min_w = MAX_BUS_W'(x_min);
        x_max_w = MAX_BUS_W'(x_max);
        y_min_w = MAX_BUS_W'(y_min);
        y_max_w = MAX_BUS_W'(y_max);
        hit     = 1'b0;
        idx     = '0;
        // min > max on an axis leaves no coordinate satisfying both bounds
        for (int unsigned i = 0; i < NUM_ROI; i++) begin
            if (!hit &&
                x >= COORD_W'(bus_field(x_min_w, i, COORD_W)) &&
                x <= COORD_W'(bus_field(x_max_w, i, COORD_W)) &&
                y >= COORD_W'(bus_field(y_min_w, i, COORD_W)) &&
                y <= COORD_W'(bus_field(y_max_w, i, COORD_W))) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/feature_point_roi.sv
// Two-stage feature-point extractor over NUM_ROI programmable regions with line cap and frame counts.
// Define FEATURE_THIN_EN to keep only the left edge of each run of hits.
module feature_point_roi
    import feature_pkg::*;
#(
    parameter int unsigned H_DISP       = 640,
    parameter int unsigned V_DISP       = 480,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned COORD_W      = COORD_W_DEF,
    parameter int unsigned NUM_ROI      = 2,
    parameter int unsigned MAX_PER_LINE = 0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          line_start,
    input  logic                          pre_de,
    input  logic [DATA_W-1:0]             pre_data,
    input  logic [COORD_W-1:0]            x_axis,
    input  logic [COORD_W-1:0]            y_axis,
    input  logic [DATA_W-1:0]             threshold,
    input  logic [NUM_ROI*COORD_W-1:0]    roi_x_min,
    input  logic [NUM_ROI*COORD_W-1:0]    roi_x_max,
    input  logic [NUM_ROI*COORD_W-1:0]    roi_y_min,
    input  logic [NUM_ROI*COORD_W-1:0]    roi_y_max,
    output logic                          feat_de,
    output logic [COORD_W-1:0]            feat_x,
    output logic [COORD_W-1:0]            feat_y,
    output logic [ROI_IDX_W(NUM_ROI)-1:0] feat_roi,
    output logic                          cnt_valid,
    output logic [NUM_ROI*CNT_W-1:0]      cnt_bus
);
    localparam int unsigned IDX_W = ROI_IDX_W(NUM_ROI);

    logic                       frame_seen;
    logic [DATA_W-1:0]          thr_sh;
    logic [NUM_ROI*COORD_W-1:0] xmin_sh, xmax_sh, ymin_sh, ymax_sh;
    logic [DATA_W-1:0]          thr_eff;
    logic [NUM_ROI*COORD_W-1:0] xmin_eff, xmax_eff, ymin_eff, ymax_eff;
    logic                       ls_eff, in_img, match_hit, raw_hit, cand;
    logic [IDX_W-1:0]           match_idx;

    logic                       s1_hit, s1_ls;
    logic [COORD_W-1:0]         s1_x, s1_y;
    logic [IDX_W-1:0]           s1_idx;
    logic                       cap_ok, emit;
    logic [CNT_W-1:0]           frame_cnt [NUM_ROI];

    // The frame_start pixel must already see the incoming configuration
    assign thr_eff  = frame_start ? threshold : thr_sh;
    assign xmin_eff = frame_start ? roi_x_min : xmin_sh;
    assign xmax_eff = frame_start ? roi_x_max : xmax_sh;
    assign ymin_eff = frame_start ? roi_y_min : ymin_sh;
    assign ymax_eff = frame_start ? roi_y_max : ymax_sh;
    assign ls_eff   = frame_start | line_start;
    assign in_img   = (x_axis < COORD_W'(H_DISP)) && (y_axis < COORD_W'(V_DISP));

    roi_match #(
        .NUM_ROI (NUM_ROI),
        .COORD_W (COORD_W)
    ) u_match (
        .x     (x_axis),
        .y     (y_axis),
        .x_min (xmin_eff),
        .x_max (xmax_eff),
        .y_min (ymin_eff),
        .y_max (ymax_eff),
        .hit   (match_hit),
        .idx   (match_idx)
    );

    assign raw_hit = pre_de & (frame_start | frame_seen) & in_img &
                     (pre_data >= thr_eff) & match_hit;

`ifdef FEATURE_THIN_EN
    logic             prev_hit;
    logic [IDX_W-1:0] prev_roi;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_hit <= 1'b0;
            prev_roi <= '0;
        end else begin
            prev_hit <= raw_hit;
            prev_roi <= raw_hit ? match_idx : '0;
        end
    end

    assign cand = raw_hit & ~(prev_hit & ~ls_eff & (prev_roi == match_idx));
`else
    assign cand = raw_hit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit <= 1'b0;
            s1_ls  <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
            s1_idx <= '0;
        end else begin
            s1_hit <= cand;
            s1_ls  <= ls_eff;
            s1_x   <= x_axis;
            s1_y   <= y_axis;
            s1_idx <= match_idx;
        end
    end

    generate
        if (MAX_PER_LINE == 0) begin : g_nocap
            assign cap_ok = 1'b1;
        end else begin : g_cap
            localparam int unsigned LC_W = $clog2(MAX_PER_LINE + 1);
            logic [LC_W-1:0] line_cnt [NUM_ROI];
            logic [LC_W-1:0] cur;

            // A hit on the line_start slot counts against the freshly cleared line
            assign cur    = s1_ls ? '0 : line_cnt[s1_idx];
            assign cap_ok = cur < LC_W'(MAX_PER_LINE);

            always_ff @(posedge clk) begin
                for (int unsigned r = 0; r < NUM_ROI; r++) begin
                    if (rst)
                        line_cnt[r] <= '0;
                    else if (s1_hit && cap_ok && s1_idx == IDX_W'(r))
                        line_cnt[r] <= cur + LC_W'(1);
                    else if (s1_ls)
                        line_cnt[r] <= '0;
                end
            end
        end
    endgenerate

    assign emit = s1_hit & cap_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            feat_de  <= 1'b0;
            feat_x   <= '0;
            feat_y   <= '0;
            feat_roi <= '0;
        end else begin
            feat_de  <= emit;
            feat_x   <= emit ? s1_x   : '0;
            feat_y   <= emit ? s1_y   : '0;
            feat_roi <= emit ? s1_idx : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_seen <= 1'b0;
            cnt_valid  <= 1'b0;
            cnt_bus    <= '0;
            thr_sh     <= '0;
            xmin_sh    <= '0;
            xmax_sh    <= '0;
            ymin_sh    <= '0;
            ymax_sh    <= '0;
            for (int unsigned r = 0; r < NUM_ROI; r++) frame_cnt[r] <= '0;
        end else begin
            cnt_valid <= frame_start & frame_seen;
            if (frame_start) begin
                frame_seen <= 1'b1;
                thr_sh     <= threshold;
                xmin_sh    <= roi_x_min;
                xmax_sh    <= roi_x_max;
                ymin_sh    <= roi_y_min;
                ymax_sh    <= roi_y_max;
                for (int unsigned r = 0; r < NUM_ROI; r++) begin
                    if (frame_seen) cnt_bus[r*CNT_W +: CNT_W] <= frame_cnt[r];
                    frame_cnt[r] <= '0;
                end
            end else begin
                for (int unsigned r = 0; r < NUM_ROI; r++) begin
                    if (emit && s1_idx == IDX_W'(r) && frame_cnt[r] != '1)
                        frame_cnt[r] <= frame_cnt[r] + CNT_W'(1);
                end
            end
        end
    end

endmodule
